// File: rtl/jt49_cmd_logger.sv
// rtl/jt49_cmd_logger.sv - jt49 register-write bus monitor logging {wait, addr, data} words into a FWFT FIFO
module jt49_cmd_logger #(
   parameter int WAIT_SHIFT = 11,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  cs_n,
   input  logic                  wr_n,
   input  logic [3:0]            addr,
   input  logic [7:0]            din,
   input  logic                  rd,
   output logic [23:0]           dout,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf,
   input  logic                  clr_ovf
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
   localparam logic [WAIT_SHIFT-1:0] PRE_ONE  = 1;

   logic [WAIT_SHIFT-1:0] pre;
   logic [11:0]           units;
   logic [23:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rptr;
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr_next;
   logic                  write;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic [23:0]           word;

   // A write is any enabled edge with both strobes low; when full, a same-cycle pop makes room
   always_comb begin
      write     = en & ~cs_n & ~wr_n;
      full      = (count == CNT_FULL);
      empty     = (count == '0);
      pop       = rd & ~empty;
      push      = write & (~full | rd);
      drop      = write & full & ~rd;
      word      = {units, addr, din};
      rptr_next = rptr + PTR_ONE;
   end

   // Inter-write timer: prescaler feeds a saturating unit counter, restarted by each logged write
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         pre   <= '0;
         units <= '0;
      end else if (push) begin
         pre   <= '0;
         units <= '0;
      end else begin
         pre <= pre + PRE_ONE;
         if (&pre && units != 12'hfff)
            units <= units + 12'd1;
      end
   end

   // Entry storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (rst_n && push)
         mem[wptr] <= word;
   end

   // Pointers and occupancy count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr_next;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Registered head word: load the new entry when it becomes head, else the next stored entry on pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (push && (empty || (count == CNT_ONE && pop))) begin
         dout <= word;
      end else if (pop && count > CNT_ONE) begin
         dout <= mem[rptr_next];
      end
   end

   // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (drop)
         ovf <= 1'b1;
      else if (clr_ovf)
         ovf <= 1'b0;
   end

endmodule

// File: tb/tb_jt49_cmd_logger.sv
// tb/tb_jt49_cmd_logger.sv - self-checking bench for jt49_cmd_logger against a queue-based reference
module tb_jt49_cmd_logger;

   localparam int WS    = 2;
   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;

   logic          clk = 1'b0;
   logic          rst_n, en, cs_n, wr_n, rd, clr_ovf;
   logic [3:0]    addr;
   logic [7:0]    din;
   logic [23:0]   dout;
   logic          empty, ovf;
   logic [DL2:0]  count;

   int            total = 0;
   int            bad   = 0;

   logic [23:0]   q[$];
   bit            m_ovf;
   int            idle_edges;
   bit            dout_zero;

   jt49_cmd_logger #(.WAIT_SHIFT(WS), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cs_n(cs_n), .wr_n(wr_n),
      .addr(addr), .din(din), .rd(rd), .dout(dout), .empty(empty),
      .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] wait_of(input int idle);
      int u;
      u = idle >> WS;
      return (u > 4095) ? 12'd4095 : 12'(u);
   endfunction

   // One clock: update the reference from the inputs seen at the edge, then compare outputs
   task automatic tick();
      bit w, full, do_pop, do_push, drop;
      logic [23:0] word;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_ovf      = 1'b0;
         idle_edges = 0;
         dout_zero  = 1'b1;
      end else begin
         w       = en && !cs_n && !wr_n;
         full    = (q.size() == DEPTH);
         do_pop  = rd && (q.size() > 0);
         do_push = w && (!full || rd);
         drop    = w && full && !rd;
         word    = {wait_of(idle_edges), addr, din};
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(word);
            dout_zero = 1'b0;
         end
         if (drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (!en || do_push) idle_edges = 0;
         else idle_edges++;
      end
      #1;
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
      else if (dout_zero) chk("dout_rst", 32'(dout), 32'h0);
   endtask

   task automatic idle(input int n);
      cs_n = 1'b1; wr_n = 1'b1; rd = 1'b0; clr_ovf = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic r);
      cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d; rd = r;
      tick();
      cs_n = 1'b1; wr_n = 1'b1; rd = 1'b0;
   endtask

   task automatic pop1();
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd = 1'b0; clr_ovf = 1'b0;
      addr = 4'h0; din = 8'h00;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_dout", 32'(dout), 32'h0);
      pop1();
      chk("rd_empty_ignored", 32'(empty), 32'h1);

      en = 1'b1;
      wr(4'h0, 8'h01, 1'b0);
      idle(8);
      wr(4'h1, 8'h22, 1'b0);
      chk("first_word", 32'(dout), 32'h000001);
      pop1();
      chk("second_word", 32'(dout), 32'h002122);
      pop1();

      wr(4'h2, 8'h33, 1'b0);
      wr(4'h3, 8'h44, 1'b0);
      pop1();
      chk("b2b_wait0", 32'(dout), 32'h000344);
      pop1();

      wr(4'h4, 8'h55, 1'b0);
      idle(20000);
      wr(4'h5, 8'h66, 1'b0);
      pop1();
      chk("wait_sat", 32'(dout), 32'hfff566);
      pop1();

      for (int i = 0; i < 5; i++) begin
         wr(4'(i + 6), 8'(8'h70 + i), 1'b0);
         idle(3);
      end
      chk("full_count", 32'(count), 32'h4);
      chk("full_ovf", 32'(ovf), 32'h1);
      wr(4'hb, 8'h99, 1'b1);
      chk("full_rd_count", 32'(count), 32'h4);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      chk("clr_ovf", 32'(ovf), 32'h0);
      for (int i = 0; i < 4; i++) pop1();

      en = 1'b0;
      for (int i = 0; i < 3; i++) wr(4'hc, 8'h11, 1'b0);
      chk("en0_count", 32'(count), 32'h0);
      en = 1'b1;
      idle(7);
      wr(4'hd, 8'hab, 1'b0);
      chk("en_rise_wait", 32'(dout), 32'h001dab);
      pop1();

      for (int i = 0; i < 3; i++) wr(4'he, 8'(i), 1'b0);
      rst_n = 1'b0; cs_n = 1'b0; wr_n = 1'b0;
      tick();
      rst_n = 1'b1; cs_n = 1'b1; wr_n = 1'b1;
      chk("midrst_count", 32'(count), 32'h0);
      chk("midrst_empty", 32'(empty), 32'h1);

      for (int i = 0; i < 3000; i++) begin
         en      = ($urandom_range(0, 15) != 0);
         cs_n    = ($urandom_range(0, 2) == 0);
         wr_n    = ($urandom_range(0, 2) == 0);
         addr    = 4'($urandom);
         din     = 8'($urandom);
         rd      = ($urandom_range(0, 2) == 0);
         clr_ovf = ($urandom_range(0, 9) == 0);
         rst_n   = ($urandom_range(0, 299) != 0);
         tick();
      end
      rst_n = 1'b1;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
